// File: rtl/wb_stage_if.sv
// MEM-to-WB bus: instruction fields from the MEM stage and register-file write port.
// The write-back stage uses the slave side; whatever feeds MEM / consumes WB uses master.
interface wb_stage_if;
    logic        m_valid;
    logic        m_wreg;
    logic [4:0]  m_rn;
    logic [1:0]  m_wsel;
    logic [2:0]  m_ldtype;
    logic [31:0] m_alu;
    logic [31:0] m_mem;
    logic [1:0]  m_addr_lo;
    logic [31:0] m_pc8;
    logic [31:0] w_d;
    logic [4:0]  w_wn;
    logic        w_we;
    logic        w_valid;

    modport slave (
        input  m_valid, m_wreg, m_rn, m_wsel, m_ldtype, m_alu, m_mem, m_addr_lo, m_pc8,
        output w_d, w_wn, w_we, w_valid
    );

    modport master (
        output m_valid, m_wreg, m_rn, m_wsel, m_ldtype, m_alu, m_mem, m_addr_lo, m_pc8,
        input  w_d, w_wn, w_we, w_valid
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back pipeline stage: result select, load extraction, one register of latency.
// Define WB_RETIRE_CNT_EN to add the retire_cnt output (retired-instruction counter).
module wb_stage (
    input  logic       clk,
    input  logic       clrn,
    input  logic       stall,
    input  logic       flush,
    wb_stage_if.slave  wb
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);

    logic [7:0]  mem_byte [4];
    logic [15:0] mem_half;
    logic [31:0] load_val;
    logic [31:0] d_next;

    logic [31:0] d_reg;
    logic [4:0]  wn_reg;
    logic        wreg_reg;
    logic        valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign mem_byte[gi] = wb.m_mem[8*gi +: 8];
        end
    endgenerate

    // Halfword position only depends on address bit 1; bit 0 is ignored.
    assign mem_half = wb.m_addr_lo[1] ? wb.m_mem[31:16] : wb.m_mem[15:0];

    always_comb begin
        load_val = wb.m_mem;
        case (wb.m_ldtype)
            3'b001:  load_val = {{24{mem_byte[wb.m_addr_lo][7]}}, mem_byte[wb.m_addr_lo]};
            3'b010:  load_val = {24'd0, mem_byte[wb.m_addr_lo]};
            3'b011:  load_val = {{16{mem_half[15]}}, mem_half};
            3'b100:  load_val = {16'd0, mem_half};
            default: load_val = wb.m_mem;
        endcase
    end

    always_comb begin
        d_next = 32'd0;
        case (wb.m_wsel)
            2'b00:   d_next = wb.m_alu;
            2'b01:   d_next = load_val;
            2'b10:   d_next = wb.m_pc8;
            default: d_next = 32'd0;
        endcase
    end

    // Flush only kills validity; data registers keep their old contents.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            d_reg     <= 32'd0;
            wn_reg    <= 5'd0;
            wreg_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (!stall) begin
            d_reg     <= d_next;
            wn_reg    <= wb.m_rn;
            wreg_reg  <= wb.m_wreg;
            valid_reg <= wb.m_valid;
        end
    end

    assign wb.w_d     = d_reg;
    assign wb.w_wn    = wn_reg;
    assign wb.w_valid = valid_reg;
    assign wb.w_we    = valid_reg & wreg_reg & (wn_reg != 5'd0);

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt_reg;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            retire_cnt_reg <= 32'd0;
        end else if (valid_reg && !stall) begin
            retire_cnt_reg <= retire_cnt_reg + 32'd1;
        end
    end

    assign retire_cnt = retire_cnt_reg;
`endif

endmodule
